// File: rtl/clamping_unit.sv
// clamping_unit: registered saturating clamp for the ALU datapath.
// Each accepted sample is limited to [lo, hi]. The result, a valid strobe
// and the clamp flags appear one clock later.
// Optional feature macro: CLAMP_DYN_BOUNDS_EN. When it is defined, the bounds
// are held in registers that reset to LO/HI and are loaded through
// cfg_we/cfg_lo/cfg_hi. When it is not defined, the bounds are the constant
// LO/HI parameters.
module clamping_unit #(
  parameter int               WIDTH  = 32,
  parameter bit               SIGNED = 1'b1,
  parameter logic [WIDTH-1:0] LO     = '0,
  parameter logic [WIDTH-1:0] HI     = WIDTH'(32'h40000000)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
`ifdef CLAMP_DYN_BOUNDS_EN
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_lo,
  input  logic [WIDTH-1:0] cfg_hi,
`endif
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             clamp_lo,
  output logic             clamp_hi
);

  typedef struct packed {
    logic             lo;
    logic             hi;
    logic [WIDTH-1:0] data;
  } clamp_t;

  // a < b, interpreted as two's complement or as unsigned depending on SIGNED
  function automatic logic less_than(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b);
    if (SIGNED) begin
      return $signed(a) < $signed(b);
    end else begin
      return a < b;
    end
  endfunction

  // Saturation: the lower-bound test wins, so lo > hi still gives a
  // deterministic result and never raises both flags
  function automatic clamp_t saturate(input logic [WIDTH-1:0] x,
                                      input logic [WIDTH-1:0] lo,
                                      input logic [WIDTH-1:0] hi);
    clamp_t r;
    r.lo   = 1'b0;
    r.hi   = 1'b0;
    r.data = x;
    if (less_than(x, lo)) begin
      r.lo   = 1'b1;
      r.data = lo;
    end else if (less_than(hi, x)) begin
      r.hi   = 1'b1;
      r.data = hi;
    end
    return r;
  endfunction

  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_hi;
  clamp_t           w_res_p0;

`ifdef CLAMP_DYN_BOUNDS_EN
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;

  // Bound registers; a write takes effect for samples on the following edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lo <= LO;
      r_hi <= HI;
    end else if (cfg_we) begin
      r_lo <= cfg_lo;
      r_hi <= cfg_hi;
    end
  end

  assign w_lo = r_lo;
  assign w_hi = r_hi;
`else
  assign w_lo = LO;
  assign w_hi = HI;
`endif

  // ---- stage p0: combinational compare and select ----
  always_comb begin
    w_res_p0 = saturate(in_data, w_lo, w_hi);
  end

  // ---- stage p1: output register ----
  logic             r_vld_p1;
  logic [WIDTH-1:0] r_data_p1;
  logic             r_lo_p1;
  logic             r_hi_p1;

  // Capture accepted samples; idle cycles drop valid but hold data and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
      r_lo_p1   <= 1'b0;
      r_hi_p1   <= 1'b0;
    end else begin
      r_vld_p1 <= in_valid;
      if (in_valid) begin
        r_data_p1 <= w_res_p0.data;
        r_lo_p1   <= w_res_p0.lo;
        r_hi_p1   <= w_res_p0.hi;
      end
    end
  end

  assign out_valid = r_vld_p1;
  assign out_data  = r_data_p1;
  assign clamp_lo  = r_lo_p1;
  assign clamp_hi  = r_hi_p1;

endmodule

// File: tb/tb_clamping_unit.sv
// Self-checking bench for clamping_unit: a signed and an unsigned instance
// share stimulus and are compared against a plain-arithmetic reference model.
module tb_clamping_unit;

  localparam logic [31:0] P_LO = 32'h00000000;
  localparam logic [31:0] P_HI = 32'h40000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        s_valid, s_lo, s_hi;
  logic [31:0] s_data;
  logic        u_valid, u_lo, u_hi;
  logic [31:0] u_data;
`ifdef CLAMP_DYN_BOUNDS_EN
  logic        cfg_we;
  logic [31:0] cfg_lo;
  logic [31:0] cfg_hi;
`endif

  int checks = 0;
  int errors = 0;

  // Expected {valid, clamp_lo, clamp_hi, data} for each instance
  logic [34:0] exp_s, exp_u;
  logic [31:0] m_lo, m_hi;

  always #5 clk = ~clk;

  clamping_unit #(.WIDTH(32), .SIGNED(1'b1), .LO(P_LO), .HI(P_HI)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
`ifdef CLAMP_DYN_BOUNDS_EN
    .cfg_we(cfg_we), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
`endif
    .out_valid(s_valid), .out_data(s_data), .clamp_lo(s_lo), .clamp_hi(s_hi));

  clamping_unit #(.WIDTH(32), .SIGNED(1'b0), .LO(P_LO), .HI(P_HI)) dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
`ifdef CLAMP_DYN_BOUNDS_EN
    .cfg_we(cfg_we), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
`endif
    .out_valid(u_valid), .out_data(u_data), .clamp_lo(u_lo), .clamp_hi(u_hi));

  // Reference: widen to 64-bit integers and apply the clamp rules directly
  function automatic logic [34:0] ref_clamp(input logic [31:0] x,
                                            input logic [31:0] lo,
                                            input logic [31:0] hi,
                                            input bit sgn);
    longint xv, lv, hv;
    if (sgn) begin
      xv = longint'($signed(x));
      lv = longint'($signed(lo));
      hv = longint'($signed(hi));
    end else begin
      xv = longint'({32'b0, x});
      lv = longint'({32'b0, lo});
      hv = longint'({32'b0, hi});
    end
    if (xv < lv)      return {1'b1, 1'b1, 1'b0, lo};
    else if (xv > hv) return {1'b1, 1'b0, 1'b1, hi};
    else              return {1'b1, 1'b0, 1'b0, x};
  endfunction

  // One clock: drive inputs on the falling edge, advance the model at the
  // rising edge, return 1 time unit later ready for sampling
  task automatic drive(input logic r, input logic v, input logic [31:0] d);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    if (r) begin
      exp_s = '0;
      exp_u = '0;
      m_lo  = P_LO;
      m_hi  = P_HI;
    end else begin
      if (v) begin
        exp_s = ref_clamp(d, m_lo, m_hi, 1'b1);
        exp_u = ref_clamp(d, m_lo, m_hi, 1'b0);
      end else begin
        exp_s[34] = 1'b0;
        exp_u[34] = 1'b0;
      end
`ifdef CLAMP_DYN_BOUNDS_EN
      if (cfg_we) begin
        m_lo = cfg_lo;
        m_hi = cfg_hi;
      end
`endif
    end
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 32'h12345678);
      checks++;
      if ({s_valid, s_lo, s_hi, s_data} !== 35'h0) begin
        errors++;
        $display("FAIL reset_s[%0d]: got v=%b lo=%b hi=%b d=%h, want all zero",
                 i, s_valid, s_lo, s_hi, s_data);
      end
      checks++;
      if ({u_valid, u_lo, u_hi, u_data} !== 35'h0) begin
        errors++;
        $display("FAIL reset_u[%0d]: got v=%b lo=%b hi=%b d=%h, want all zero",
                 i, u_valid, u_lo, u_hi, u_data);
      end
    end
  endtask

  task automatic test_directed;
    logic [31:0] xs [4];
    logic [34:0] ws [4];
    logic [34:0] wu [4];
    xs = '{32'hFFFFFFFF, 32'h80000000, 32'h40000000, 32'h40000001};
    ws = '{{3'b110, 32'h0}, {3'b110, 32'h0}, {3'b100, 32'h40000000}, {3'b101, 32'h40000000}};
    wu = '{{3'b101, 32'h40000000}, {3'b101, 32'h40000000}, {3'b100, 32'h40000000}, {3'b101, 32'h40000000}};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, xs[i]);
      checks++;
      if ({s_valid, s_lo, s_hi, s_data} !== ws[i]) begin
        errors++;
        $display("FAIL directed_s x=%h: got %h, want %h", xs[i], {s_valid, s_lo, s_hi, s_data}, ws[i]);
      end
      checks++;
      if ({u_valid, u_lo, u_hi, u_data} !== wu[i]) begin
        errors++;
        $display("FAIL directed_u x=%h: got %h, want %h", xs[i], {u_valid, u_lo, u_hi, u_data}, wu[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] xs [4];
    logic        vs [4];
    logic [34:0] ws [4];
    xs = '{32'd5, 32'h7FFFFFFF, 32'd0, 32'hDEADBEEF};
    vs = '{1'b1, 1'b1, 1'b1, 1'b0};
    ws = '{{3'b100, 32'd5}, {3'b101, 32'h40000000}, {3'b100, 32'd0}, {3'b000, 32'd0}};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, vs[i], xs[i]);
      checks++;
      if ({s_valid, s_lo, s_hi, s_data} !== ws[i]) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %h, want %h", i, {s_valid, s_lo, s_hi, s_data}, ws[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] x;
    logic        v, r;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0:       x = P_HI + 32'($urandom_range(0, 2)) - 32'd1;
        1:       x = P_LO + 32'($urandom_range(0, 2)) - 32'd1;
        2:       x = 32'h7FFFFFFF + 32'($urandom_range(0, 1));
        default: x = $urandom;
      endcase
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 49) == 0);
      drive(r, v, x);
      checks++;
      if ({s_valid, s_lo, s_hi, s_data} !== exp_s) begin
        errors++;
        $display("FAIL random_s[%0d] x=%h v=%b r=%b: got %h, want %h",
                 i, x, v, r, {s_valid, s_lo, s_hi, s_data}, exp_s);
      end
      checks++;
      if ({u_valid, u_lo, u_hi, u_data} !== exp_u) begin
        errors++;
        $display("FAIL random_u[%0d] x=%h v=%b r=%b: got %h, want %h",
                 i, x, v, r, {u_valid, u_lo, u_hi, u_data}, exp_u);
      end
    end
  endtask

`ifdef CLAMP_DYN_BOUNDS_EN
  task automatic test_dyn_bounds;
    logic [31:0] xs [4];
    logic        ws_we [4];
    logic [34:0] ws [4];
    xs    = '{32'hFFFFFFEC, 32'hFFFFFFEC, 32'd20, 32'd3};
    ws_we = '{1'b1, 1'b0, 1'b0, 1'b0};
    ws    = '{{3'b110, 32'h0}, {3'b110, 32'hFFFFFFF6}, {3'b101, 32'd10}, {3'b100, 32'd3}};
    cfg_lo = 32'hFFFFFFF6;
    cfg_hi = 32'd10;
    for (int i = 0; i < 4; i++) begin
      cfg_we = ws_we[i];
      drive(1'b0, 1'b1, xs[i]);
      checks++;
      if ({s_valid, s_lo, s_hi, s_data} !== ws[i]) begin
        errors++;
        $display("FAIL dyn_s[%0d]: got %h, want %h", i, {s_valid, s_lo, s_hi, s_data}, ws[i]);
      end
      checks++;
      if ({u_valid, u_lo, u_hi, u_data} !== exp_u) begin
        errors++;
        $display("FAIL dyn_u[%0d]: got %h, want %h", i, {u_valid, u_lo, u_hi, u_data}, exp_u);
      end
    end
    cfg_we = 1'b0;
  endtask
`endif

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    exp_s    = '0;
    exp_u    = '0;
    m_lo     = P_LO;
    m_hi     = P_HI;
`ifdef CLAMP_DYN_BOUNDS_EN
    cfg_we   = 1'b0;
    cfg_lo   = '0;
    cfg_hi   = '0;
`endif
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
`ifdef CLAMP_DYN_BOUNDS_EN
    test_dyn_bounds();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clamping_unit.md
Name: clamping_unit

Overview:
Registered saturating clamp for the ALU datapath. Each accepted sample x is limited to the closed range [LO, HI]. The result appears one clock later with a valid strobe and flags that show which bound, if any, was applied. It sits after arithmetic stages to keep results inside a legal range, for example non-negative activations.

Parameters:
WIDTH, 32, data width in bits (≥2).
SIGNED, 1, 1 = compare as two's complement; 0 = compare as unsigned.
LO, 32'h00000000, lower bound, interpreted per SIGNED.
HI, 32'h40000000, upper bound, interpreted per SIGNED.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  in_data is valid this cycle.
in_data  input  WIDTH  sample to clamp.
out_valid  output  1  out_data and flags are valid.
out_data  output  WIDTH  clamped result.
clamp_lo  output  1  result was forced to the lower bound.
clamp_hi  output  1  result was forced to the upper bound.

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset: on any rising edge with rst=1, out_valid=0, out_data=0, clamp_lo=0, clamp_hi=0. Reset overrides a simultaneous in_valid. A sample presented in the reset cycle is discarded.
- Latency: exactly 1 cycle. in_valid=1 at edge N gives out_valid=1 after edge N.
- Throughput: one sample per cycle. There is no backpressure and no ready signal.
- in_valid=0: out_valid goes to 0 on the next edge. out_data and the flags hold their last values.
- Comparison is signed when SIGNED=1 and unsigned when SIGNED=0.
- Evaluation order for effective bounds lo and hi:
  - if x < lo: out_data = lo, clamp_lo = 1, clamp_hi = 0.
  - else if x > hi: out_data = hi, clamp_hi = 1, clamp_lo = 0.
  - else: out_data = x, both flags 0.
- Boundary values are inside the range. x == lo or x == hi passes through unchanged with no flag set.
- Misconfigured bounds (lo > hi): the lower-bound check has priority, so results are deterministic. Never assert both flags at once.
- Fully combinational compare, one register stage. No wrap-around: output is always a bound or the input, never an arithmetic result.

Optional Feature:
- Macro CLAMP_DYN_BOUNDS_EN.
- When defined:
  - Adds ports cfg_we (input, 1), cfg_lo (input, WIDTH) and cfg_hi (input, WIDTH).
  - Bound registers reset to the LO and HI parameters.
  - When cfg_we=1 on an edge, both bound registers load cfg_lo and cfg_hi.
  - New bounds apply to samples accepted on the edge after the write. A sample on the same edge as the write uses the old bounds.
- When undefined: these ports do not exist and the bounds are the constant LO and HI parameters.

Test Plan:
- Default parameters, rst=1 for 2 cycles with in_valid=1 and in_data=32'h12345678 -> out_valid=0, out_data=0, both flags 0.
- in_data=32'hFFFFFFFF (−1) -> next cycle out_data=32'h00000000, clamp_lo=1, out_valid=1.
- in_data=32'h80000000 (most negative) -> out_data=32'h00000000, clamp_lo=1. With SIGNED=0: out_data=32'h40000000, clamp_hi=1.
- in_data=32'h40000000 (equals HI) -> out_data=32'h40000000, no flags. in_data=32'h40000001 -> out_data=32'h40000000, clamp_hi=1.
- Back-to-back stream 5, 32'h7FFFFFFF, 0, then in_valid=0 -> outputs 5, 32'h40000000 (clamp_hi), 0 on consecutive cycles, then out_valid=0 with out_data held at 0.
- With CLAMP_DYN_BOUNDS_EN: write cfg_lo=−10, cfg_hi=10. Then in_data=−20 -> −10 with clamp_lo=1. in_data=20 -> 10 with clamp_hi=1. A sample on the write edge uses the old bounds 0 and 32'h40000000.
